// File: rtl/vend_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// vend_transaction_sequencer
//
// Sequences one vending transaction. Coin credit is accumulated, a product
// selection is checked against the stock and price reported by the product
// manager, a one-cycle buy strobe is fired, and the remaining credit is paid
// back one coin per handshake with the coin ejector.
//
// Parameters
//   PRICE_UNIT      credit units per product price unit
//                   (cost = unit_price * qty * PRICE_UNIT)
//   TIMEOUT_CYCLES  idle CREDIT cycles before an automatic full refund
//                   (exists only when VEND_TIMEOUT_EN is defined)
//
// Build option
//   VEND_TIMEOUT_EN  when defined, an idle counter in CREDIT forces a refund
//                    after TIMEOUT_CYCLES consecutive idle cycles. When
//                    undefined, CREDIT waits indefinitely.
//
// Ports
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous reset, active low (0 = reset)
//   coin_valid    in   1   coin event this cycle
//   coin          in   2   00=500 01=1000 10=2000 11=5000
//   sel_valid     in   1   selection request this cycle
//   sel_id        in   3   product id
//   sel_qty       in   4   quantity
//   cancel        in   1   refund request
//   unit_price    in   8   price of the latched id (combinational from manager)
//   stock         in   5   stock of the latched id (combinational from manager)
//   change_ready  in   1   ejector accepts change_coin this cycle
//   coin_ack      out  1   coin accepted into credit this cycle
//   buy_pulse     out  1   one-cycle purchase strobe
//   buy_id        out  3   latched product id
//   buy_qty       out  4   latched quantity
//   change_valid  out  1   change_coin is valid
//   change_coin   out  2   coin code to eject, same encoding as coin
//   credit        out  16  current credit
//   err           out  2   00 none, 01 stock/qty, 10 funds, 11 credit overflow
//   state         out  3   IDLE=0 CREDIT=1 CHECK=2 VEND=3 CHANGE=4
// -----------------------------------------------------------------------------
module vend_transaction_sequencer #(
  parameter int unsigned PRICE_UNIT = 100
`ifdef VEND_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin_valid,
  input  logic [1:0]  coin,
  input  logic        sel_valid,
  input  logic [2:0]  sel_id,
  input  logic [3:0]  sel_qty,
  input  logic        cancel,
  input  logic [7:0]  unit_price,
  input  logic [4:0]  stock,
  input  logic        change_ready,
  output logic        coin_ack,
  output logic        buy_pulse,
  output logic [2:0]  buy_id,
  output logic [3:0]  buy_qty,
  output logic        change_valid,
  output logic [1:0]  change_coin,
  output logic [15:0] credit,
  output logic [1:0]  err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_QTY   = 2'b01;
  localparam logic [1:0] ERR_FUNDS = 2'b10;
  localparam logic [1:0] ERR_OVFL  = 2'b11;

  localparam logic [15:0] MIN_COIN = 16'd500;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

  state_e      state_q, state_d;
  logic [15:0] credit_q, credit_d;
  logic [2:0]  buy_id_q, buy_id_d;
  logic [3:0]  buy_qty_q, buy_qty_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] cost_q, cost_d;
`ifdef VEND_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  logic [15:0] coin_value;
  logic [16:0] credit_sum;
  logic        coin_open;
  logic        coin_fits;
  logic        coin_take;
  logic [15:0] coin_credit;
  logic [23:0] cost_calc;
  logic        qty_bad;
  logic        funds_bad;
  logic [1:0]  chg_code;
  logic [15:0] chg_value;
  logic        chg_avail;

  // Coin decode and the overflow-safe credit sum. The sum is one bit wider
  // than the credit so that a carry out means the coin would not fit.
  always_comb begin
    coin_value = 16'd500;
    case (coin)
      2'b00:   coin_value = 16'd500;
      2'b01:   coin_value = 16'd1000;
      2'b10:   coin_value = 16'd2000;
      default: coin_value = 16'd5000;
    endcase
    credit_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    coin_open   = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
    coin_fits   = ~credit_sum[16];
    coin_take   = coin_valid && coin_open && coin_fits;
    coin_credit = coin_take ? credit_sum[15:0] : credit_q;
  end

  // Purchase checks against the product manager's view of the latched id.
  // The cost is kept 24 bits wide so a large price never wraps into a
  // falsely affordable value; only its low 16 bits are kept for VEND, which
  // is reached only when the cost does not exceed the 16-bit credit.
  always_comb begin
    cost_calc = 24'(unit_price) * 24'(buy_qty_q) * 24'(PRICE_UNIT);
    qty_bad   = (buy_qty_q == 4'd0) || ({1'b0, buy_qty_q} > stock);
    funds_bad = cost_calc > {8'd0, credit_q};
  end

  // Greedy change selection: the largest coin not exceeding the credit.
  // Below the smallest coin there is nothing to eject.
  always_comb begin
    chg_avail = credit_q >= MIN_COIN;
    if (credit_q >= 16'd5000) begin
      chg_code  = 2'b11;
      chg_value = 16'd5000;
    end else if (credit_q >= 16'd2000) begin
      chg_code  = 2'b10;
      chg_value = 16'd2000;
    end else if (credit_q >= 16'd1000) begin
      chg_code  = 2'b01;
      chg_value = 16'd1000;
    end else begin
      chg_code  = 2'b00;
      chg_value = MIN_COIN;
    end
  end

  // State and datapath registers. Reset aborts any transaction in flight,
  // discarding credit and any change still owed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      credit_q  <= 16'd0;
      buy_id_q  <= 3'd0;
      buy_qty_q <= 4'd0;
      err_q     <= ERR_NONE;
      cost_q    <= 16'd0;
`ifdef VEND_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      buy_id_q  <= buy_id_d;
      buy_qty_q <= buy_qty_d;
      err_q     <= err_d;
      cost_q    <= cost_d;
`ifdef VEND_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    buy_id_d  = buy_id_q;
    buy_qty_d = buy_qty_q;
    err_d     = err_q;
    cost_d    = cost_q;
`ifdef VEND_TIMEOUT_EN
    timer_d   = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        credit_d = coin_credit;
        if (coin_take) begin
          state_d = ST_CREDIT;
        end
      end

      ST_CREDIT: begin
        // A coin arriving with cancel or sel_valid still lands in credit, so
        // the refund or the affordability check sees the updated amount.
        credit_d = coin_credit;
        if (cancel) begin
          state_d = (coin_credit != 16'd0) ? ST_CHANGE : ST_IDLE;
        end else if (sel_valid) begin
          buy_id_d  = sel_id;
          buy_qty_d = sel_qty;
          err_d     = ERR_NONE;
          state_d   = ST_CHECK;
        end
`ifdef VEND_TIMEOUT_EN
        else if (!coin_take && (timer_q == TIMER_LAST)) begin
          state_d = ST_CHANGE;
        end
        if (!cancel && !sel_valid && !coin_take && (timer_q != TIMER_LAST)) begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end

      ST_CHECK: begin
        cost_d = cost_calc[15:0];
        if (qty_bad) begin
          err_d   = ERR_QTY;
          state_d = ST_CREDIT;
        end else if (funds_bad) begin
          err_d   = ERR_FUNDS;
          state_d = ST_CREDIT;
        end else begin
          state_d = ST_VEND;
        end
      end

      ST_VEND: begin
        credit_d = credit_q - cost_q;
        state_d  = (credit_d != 16'd0) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        // The presented coin stays put until accepted because credit only
        // moves on a handshake. A residue below the smallest coin is dropped.
        if (chg_avail) begin
          if (change_ready) begin
            credit_d = credit_q - chg_value;
          end
        end else begin
          credit_d = 16'd0;
        end
        state_d = (credit_d == 16'd0) ? ST_IDLE : ST_CHANGE;
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = 16'd0;
      end
    endcase

    // A rejected coin flags overflow; an accepted one clears any old error.
    if (coin_valid && coin_open && !coin_fits) begin
      err_d = ERR_OVFL;
    end else if (coin_take) begin
      err_d = ERR_NONE;
    end
  end

  // Outputs: strobes decode directly from the current state.
  always_comb begin
    coin_ack     = coin_take;
    buy_pulse    = (state_q == ST_VEND);
    buy_id       = buy_id_q;
    buy_qty      = buy_qty_q;
    change_valid = (state_q == ST_CHANGE) && chg_avail;
    change_coin  = chg_code;
    credit       = credit_q;
    err          = err_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_vend_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_transaction_sequencer
//
// Directed bench for vend_transaction_sequencer. Expected buy strobes and
// change coins are queued when the stimulus is issued; a monitor on the
// falling edge pops them whenever the DUT presents a buy pulse or a change
// handshake. Register state is checked directly against hand-computed values.
// A small product table stands in for the product manager.
// -----------------------------------------------------------------------------
module tb_vend_transaction_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        coin_valid;
  logic [1:0]  coin;
  logic        sel_valid;
  logic [2:0]  sel_id;
  logic [3:0]  sel_qty;
  logic        cancel;
  logic [7:0]  unit_price;
  logic [4:0]  stock;
  logic        change_ready;
  logic        coin_ack;
  logic        buy_pulse;
  logic [2:0]  buy_id;
  logic [3:0]  buy_qty;
  logic        change_valid;
  logic [1:0]  change_coin;
  logic [15:0] credit;
  logic [1:0]  err;
  logic [2:0]  state;

  typedef struct {
    logic [2:0] id;
    logic [3:0] qty;
    int         cyc;
  } buy_exp_t;

  buy_exp_t   buy_q[$];
  logic [1:0] change_q[$];
  buy_exp_t   mon_buy;
  logic [1:0] mon_chg;
  logic       held_valid = 1'b0;
  logic [1:0] held_coin  = 2'b00;
  logic       last_ack;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  vend_transaction_sequencer #(
    .PRICE_UNIT(100)
`ifdef VEND_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .sel_qty      (sel_qty),
    .cancel       (cancel),
    .unit_price   (unit_price),
    .stock        (stock),
    .change_ready (change_ready),
    .coin_ack     (coin_ack),
    .buy_pulse    (buy_pulse),
    .buy_id       (buy_id),
    .buy_qty      (buy_qty),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .credit       (credit),
    .err          (err),
    .state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Product manager stand-in: id1 price 15 stock 3, id2 price 5 stock 2.
  always_comb begin
    case (buy_id)
      3'd1: begin unit_price = 8'd15; stock = 5'd3; end
      3'd2: begin unit_price = 8'd5;  stock = 5'd2; end
      default: begin unit_price = 8'd20; stock = 5'd0; end
    endcase
  end

  // Monitor: consumes queued expectations on buy pulses and change
  // handshakes, and checks that a presented change coin holds while stalled.
  always @(negedge clk) begin
    if (reset) begin
      if (buy_pulse) begin
        checks++;
        if (buy_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL buy_pulse: got unexpected pulse id=%0d qty=%0d, required none", buy_id, buy_qty);
        end else begin
          mon_buy = buy_q.pop_front();
          if (buy_id !== mon_buy.id || buy_qty !== mon_buy.qty || cyc != mon_buy.cyc) begin
            errors++;
            $display("[TB] FAIL buy_pulse: got id=%0d qty=%0d cycle=%0d, required id=%0d qty=%0d cycle=%0d",
                     buy_id, buy_qty, cyc, mon_buy.id, mon_buy.qty, mon_buy.cyc);
          end
        end
      end
      if (change_valid && change_ready) begin
        checks++;
        if (change_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL change_coin: got unexpected coin %0d, required none", change_coin);
        end else begin
          mon_chg = change_q.pop_front();
          if (change_coin !== mon_chg) begin
            errors++;
            $display("[TB] FAIL change_coin: got %0d required %0d", change_coin, mon_chg);
          end
        end
      end
      if (change_valid && held_valid) begin
        checks++;
        if (change_coin !== held_coin) begin
          errors++;
          $display("[TB] FAIL change_stable: got %0d required %0d", change_coin, held_coin);
        end
      end
      held_valid = change_valid && !change_ready;
      held_coin  = change_coin;
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs starting just after a rising edge; coin_ack
  // is captured mid-cycle before the inputs are released.
  task automatic applyStimulus(input logic cv, input logic [1:0] code, input logic sv,
                               input logic [2:0] id, input logic [3:0] qty, input logic cn);
    coin_valid = cv;
    coin       = code;
    sel_valid  = sv;
    sel_id     = id;
    sel_qty    = qty;
    cancel     = cn;
    @(negedge clk);
    last_ack = coin_ack;
    tick();
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic insertCoin(input logic [1:0] code, input logic exp_ack);
    applyStimulus(1'b1, code, 1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("coin_ack", int'(last_ack), int'(exp_ack));
  endtask

  task automatic selectProduct(input logic [2:0] id, input logic [3:0] qty);
    applyStimulus(1'b0, 2'b00, 1'b1, id, qty, 1'b0);
  endtask

  // Waits for a state with a cycle budget. Mode 0 keeps change_ready high,
  // mode 1 raises it only every third cycle.
  task automatic waitState(input logic [2:0] target, input int budget, input int mode);
    int k;
    k = 0;
    while (state !== target && k < budget) begin
      change_ready = (mode == 0) ? 1'b1 : ((k % 3) == 2);
      tick();
      k++;
    end
    change_ready = 1'b1;
    checkOutput("wait_state", int'(state), int'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    coin_valid   = 1'b0;
    coin         = 2'b00;
    sel_valid    = 1'b0;
    sel_id       = 3'd0;
    sel_qty      = 4'd0;
    cancel       = 1'b0;
    change_ready = 1'b1;
    last_ack     = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_credit", int'(credit), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_buy_id", int'(buy_id), 0);
    checkOutput("reset_buy_qty", int'(buy_qty), 0);
    checkOutput("reset_strobes", int'({buy_pulse, change_valid, coin_ack}), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // 500 + 500 + 1000, buy id1 qty1 (1500), 500 change
    $display("[TB] purchase with change");
    insertCoin(2'b00, 1'b1);
    checkOutput("state_credit", int'(state), 1);
    insertCoin(2'b00, 1'b1);
    insertCoin(2'b01, 1'b1);
    checkOutput("credit_2000", int'(credit), 2000);
    buy_q.push_back('{id: 3'd1, qty: 4'd1, cyc: cyc + 2});
    change_q.push_back(2'b00);
    selectProduct(3'd1, 4'd1);
    checkOutput("state_check", int'(state), 2);
    tick();
    checkOutput("state_vend", int'(state), 3);
    tick();
    checkOutput("credit_after_vend", int'(credit), 500);
    waitState(3'd0, 20, 0);
    checkOutput("credit_idle", int'(credit), 0);

    // Insufficient funds
    $display("[TB] insufficient funds");
    insertCoin(2'b01, 1'b1);
    selectProduct(3'd1, 4'd1);
    tick();
    checkOutput("funds_state", int'(state), 1);
    checkOutput("funds_err", int'(err), 2);
    checkOutput("funds_credit", int'(credit), 1000);

    // Quantity zero, then above stock, then exactly stock and exact credit
    $display("[TB] quantity checks");
    selectProduct(3'd1, 4'd0);
    checkOutput("err_cleared_by_sel", int'(err), 0);
    tick();
    checkOutput("qty0_err", int'(err), 1);
    checkOutput("qty0_state", int'(state), 1);
    selectProduct(3'd1, 4'd4);
    tick();
    checkOutput("qty_over_err", int'(err), 1);
    checkOutput("qty_over_credit", int'(credit), 1000);
    buy_q.push_back('{id: 3'd2, qty: 4'd2, cyc: cyc + 2});
    selectProduct(3'd2, 4'd2);
    tick();
    checkOutput("exact_vend", int'(state), 3);
    tick();
    checkOutput("exact_idle", int'(state), 0);
    checkOutput("exact_credit", int'(credit), 0);

    // 8500 refunded greedily with a stalling ejector
    $display("[TB] cancel refund");
    insertCoin(2'b11, 1'b1);
    insertCoin(2'b10, 1'b1);
    insertCoin(2'b01, 1'b1);
    insertCoin(2'b00, 1'b1);
    checkOutput("credit_8500", int'(credit), 8500);
    change_q.push_back(2'b11);
    change_q.push_back(2'b10);
    change_q.push_back(2'b01);
    change_q.push_back(2'b00);
    change_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b1, 3'd1, 4'd1, 1'b1);
    checkOutput("cancel_state", int'(state), 4);
    waitState(3'd0, 40, 1);
    checkOutput("refund_credit", int'(credit), 0);

    // Overflow near the top of the credit range, then reset mid-change
    $display("[TB] overflow and reset");
    for (int i = 0; i < 13; i++) begin
      insertCoin(2'b11, 1'b1);
    end
    checkOutput("credit_65000", int'(credit), 65000);
    insertCoin(2'b11, 1'b0);
    checkOutput("ovfl_err", int'(err), 3);
    checkOutput("ovfl_credit", int'(credit), 65000);
    insertCoin(2'b00, 1'b1);
    checkOutput("ovfl_cleared", int'(err), 0);
    checkOutput("credit_65500", int'(credit), 65500);
    change_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkOutput("change_state", int'(state), 4);
    checkOutput("change_valid", int'(change_valid), 1);
    checkOutput("change_first_coin", int'(change_coin), 3);
    insertCoin(2'b00, 1'b0);
    checkOutput("change_credit_held", int'(credit), 65500);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_state", int'(state), 0);
    checkOutput("abort_credit", int'(credit), 0);
    checkOutput("abort_change_valid", int'(change_valid), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    change_ready = 1'b1;
    tick();
    checkOutput("after_reset_state", int'(state), 0);

`ifdef VEND_TIMEOUT_EN
    // Idle timeout refunds the whole credit after 8 idle cycles
    $display("[TB] idle timeout");
    insertCoin(2'b01, 1'b1);
    change_q.push_back(2'b01);
    repeat (7) tick();
    checkOutput("timeout_not_yet", int'(state), 1);
    tick();
    checkOutput("timeout_change", int'(state), 4);
    waitState(3'd0, 20, 0);
    checkOutput("timeout_credit", int'(credit), 0);
`endif

    repeat (3) tick();
    checkOutput("buy_queue_drained", buy_q.size(), 0);
    checkOutput("change_queue_drained", change_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
